ahb_master_burst: RTL and testbench

AHB_MASTER_BURST -- requirements
Module: ahb_master_burst

---
 rtl/ahb_master_burst.sv | 203 ++++++++++++++++++++
 tb/tb_ahb_master_burst.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_burst.sv
// AHB-Lite style burst master: turns one command into a SINGLE/INCR/WRAP burst with re-arbitration on grant loss.
// Latency: command accept -> REQ next cycle; first address phase one edge after HGRANT&HREADY; done one cycle after last data phase.
// Backpressure: cmd_ready only in IDLE; HREADY=0 stalls address/data phases; wdata is consumed when wdata_ready is high.
//
// Ports:
//   HCLK, HRESET                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready, cmd_addr,
//   cmd_burst, cmd_len, cmd_write      command handshake and burst description
//   wdata/wdata_ready                  write data for the current data phase
//   rdata/rdata_valid                  captured read data, one-cycle qualifier
//   done                               pulse after the final data phase
//   HBUSREQ, HGRANT, HREADY, HADDR,
//   HTRANS, HBURST, HWRITE, HSIZE,
//   HWDATA, HRDATA                     AHB master bus signals
module ahb_master_burst #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_burst,
  input  logic [4:0]        cmd_len,
  input  logic              cmd_write,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              HBUSREQ,
  input  logic              HGRANT,
  input  logic              HREADY,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic [2:0]        HBURST,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR   = 3'b001;
  localparam logic [2:0] BURST_WRAP4  = 3'b010;
  localparam logic [2:0] BURST_INCR4  = 3'b011;
  localparam logic [2:0] BURST_WRAP8  = 3'b100;
  localparam logic [2:0] BURST_INCR8  = 3'b101;
  localparam logic [2:0] BURST_WRAP16 = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ADDR,
    S_LAST_DATA
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   haddr_q;
  logic [1:0]          htrans_q;
  logic [2:0]          hburst_q;
  logic [2:0]          burst_q;    // original command burst, drives the wrap arithmetic
  logic                hwrite_q;
  logic                hbusreq_q;
  logic [4:0]          beats_q;    // address phases still to be issued, including the one on the bus
  logic                rearb_q;    // set once the burst has been split by a grant loss
  logic                dphase_q;   // a data phase is in progress
  logic [DATA_W-1:0]   rdata_q;
  logic                rdata_valid_q;
  logic                done_q;

  logic [ADDR_W-1:0]   haddr_d;
  logic [ADDR_W-1:0]   addr_inc;
  logic [ADDR_W-1:0]   wrap_mask;
  logic [4:0]          beats_d;

  // Next beat address: wrapping bursts only touch the bits inside their aligned block.
  always_comb begin
    wrap_mask = '0;
    case (burst_q)
      BURST_WRAP4:  wrap_mask = ADDR_W'(6'h0C);
      BURST_WRAP8:  wrap_mask = ADDR_W'(6'h1C);
      BURST_WRAP16: wrap_mask = ADDR_W'(6'h3C);
      default:      wrap_mask = '0;
    endcase
    addr_inc = haddr_q + ADDR_W'(4);
    if (wrap_mask != '0) begin
      haddr_d = (haddr_q & ~wrap_mask) | (addr_inc & wrap_mask);
    end else begin
      haddr_d = addr_inc;
    end
  end

  // Beat count from the command; cmd_len only matters for INCR.
  always_comb begin
    beats_d = 5'd16;
    case (cmd_burst)
      BURST_SINGLE:             beats_d = 5'd1;
      BURST_INCR:               beats_d = (cmd_len == 5'd0) ? 5'd1 : cmd_len;
      BURST_WRAP4, BURST_INCR4: beats_d = 5'd4;
      BURST_WRAP8, BURST_INCR8: beats_d = 5'd8;
      default:                  beats_d = 5'd16;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q       <= S_IDLE;
      haddr_q       <= '0;
      htrans_q      <= TRANS_IDLE;
      hburst_q      <= BURST_SINGLE;
      burst_q       <= BURST_SINGLE;
      hwrite_q      <= 1'b0;
      hbusreq_q     <= 1'b0;
      beats_q       <= 5'd0;
      rearb_q       <= 1'b0;
      dphase_q      <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      rdata_valid_q <= 1'b0;

      // Pipelined bus: each HREADY edge closes the current data phase and
      // opens a new one if an address phase is accepted on the same edge.
      if (HREADY) begin
        dphase_q <= (state_q == S_ADDR);
        if (dphase_q && !hwrite_q) begin
          rdata_q       <= HRDATA;
          rdata_valid_q <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            haddr_q   <= cmd_addr;
            burst_q   <= cmd_burst;
            hburst_q  <= cmd_burst;
            hwrite_q  <= cmd_write;
            beats_q   <= beats_d;
            rearb_q   <= 1'b0;
            hbusreq_q <= 1'b1;
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          if (HGRANT && HREADY) begin
            htrans_q <= TRANS_NONSEQ;
            // A split burst is finished as an undefined-length INCR.
            hburst_q <= rearb_q ? BURST_INCR : burst_q;
            state_q  <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (HREADY) begin
            haddr_q <= haddr_d;
            beats_q <= beats_q - 5'd1;
            if (beats_q == 5'd1) begin
              // Final beat goes out regardless of grant.
              htrans_q  <= TRANS_IDLE;
              hbusreq_q <= 1'b0;
              state_q   <= S_LAST_DATA;
            end else if (!HGRANT) begin
              htrans_q <= TRANS_IDLE;
              rearb_q  <= 1'b1;
              state_q  <= S_REQ;
            end else begin
              htrans_q <= TRANS_SEQ;
            end
          end
        end
        S_LAST_DATA: begin
          if (HREADY) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign HADDR       = haddr_q;
  assign HTRANS      = htrans_q;
  assign HBURST      = hburst_q;
  assign HWRITE      = hwrite_q;
  assign HBUSREQ     = hbusreq_q;
  assign HSIZE       = 3'b010;
  assign HWDATA      = (dphase_q && hwrite_q) ? wdata : '0;
  assign wdata_ready = dphase_q && hwrite_q && HREADY;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign done        = done_q;

endmodule

// File: tb/tb_ahb_master_burst.sv
// Directed bench for ahb_master_burst: reset, INCR4 write, WRAP8 read, HREADY stall,
// grant loss / regrant, mid-burst reset, SINGLE and zero-length INCR.
// Inputs change 1 time unit after the rising edge; outputs are sampled there as well.
module tb_ahb_master_burst;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              HCLK;
  logic              HRESET;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [2:0]        cmd_burst;
  logic [4:0]        cmd_len;
  logic              cmd_write;
  logic [DATA_W-1:0] wdata;
  logic              wdata_ready;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              done;
  logic              HBUSREQ;
  logic              HGRANT;
  logic              HREADY;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic [2:0]        HBURST;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA;

  int vectors;
  int miscompares;

  logic [31:0] wd   [4];
  logic [31:0] exp8 [8];

  ahb_master_burst #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_burst(cmd_burst), .cmd_len(cmd_len), .cmd_write(cmd_write),
    .wdata(wdata), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done),
    .HBUSREQ(HBUSREQ), .HGRANT(HGRANT), .HREADY(HREADY),
    .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check_reset(input string p);
    chk({p, " cmd_ready"},   64'(cmd_ready),   64'd1);
    chk({p, " HBUSREQ"},     64'(HBUSREQ),     64'd0);
    chk({p, " HTRANS"},      64'(HTRANS),      64'd0);
    chk({p, " HADDR"},       64'(HADDR),       64'd0);
    chk({p, " HBURST"},      64'(HBURST),      64'd0);
    chk({p, " HWRITE"},      64'(HWRITE),      64'd0);
    chk({p, " HWDATA"},      64'(HWDATA),      64'd0);
    chk({p, " wdata_ready"}, 64'(wdata_ready), 64'd0);
    chk({p, " rdata"},       64'(rdata),       64'd0);
    chk({p, " rdata_valid"}, 64'(rdata_valid), 64'd0);
    chk({p, " done"},        64'(done),        64'd0);
    chk({p, " HSIZE"},       64'(HSIZE),       64'd2);
  endtask

  // Presents a command in an IDLE cycle; returns in the first REQ cycle.
  task automatic issue(input string p, input logic [31:0] a, input logic [2:0] b,
                       input logic [4:0] l, input logic w);
    chk({p, " cmd_ready idle"}, 64'(cmd_ready), 64'd1);
    cmd_addr  = a;
    cmd_burst = b;
    cmd_len   = l;
    cmd_write = w;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk({p, " req HBUSREQ"},   64'(HBUSREQ),   64'd1);
    chk({p, " req HTRANS"},    64'(HTRANS),    64'd0);
    chk({p, " req cmd_ready"}, 64'(cmd_ready), 64'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    HRESET = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_burst = '0; cmd_len = '0;
    cmd_write = 1'b0; wdata = '0; HGRANT = 1'b1; HREADY = 1'b1; HRDATA = '0;
    wd[0] = 32'hA0A0_0001; wd[1] = 32'hB1B1_0002; wd[2] = 32'hC2C2_0003; wd[3] = 32'hD3D3_0004;
    exp8[0] = 32'h38; exp8[1] = 32'h3C; exp8[2] = 32'h20; exp8[3] = 32'h24;
    exp8[4] = 32'h28; exp8[5] = 32'h2C; exp8[6] = 32'h30; exp8[7] = 32'h34;

    // ---- reset values
    step();
    step();
    check_reset("rst");
    HRESET = 1'b0;
    step();

    // ---- INCR4 write at 0x100
    issue("t1", 32'h100, 3'b011, 5'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t1 HADDR[%0d]", i), 64'(HADDR), 64'(32'h100 + 4 * i));
      chk($sformatf("t1 HTRANS[%0d]", i), 64'(HTRANS), (i == 0) ? 64'd2 : 64'd3);
      if (i == 0) begin
        chk("t1 HBURST", 64'(HBURST), 64'd3);
        chk("t1 HWRITE", 64'(HWRITE), 64'd1);
        #1;
        chk("t1 no wdata_ready in first addr", 64'(wdata_ready), 64'd0);
      end else begin
        wdata = wd[i-1];
        #1;
        chk($sformatf("t1 wdata_ready[%0d]", i - 1), 64'(wdata_ready), 64'd1);
        chk($sformatf("t1 HWDATA[%0d]", i - 1), 64'(HWDATA), 64'(wd[i-1]));
      end
    end
    step();
    chk("t1 last HTRANS", 64'(HTRANS), 64'd0);
    chk("t1 last HBUSREQ", 64'(HBUSREQ), 64'd0);
    chk("t1 no early done", 64'(done), 64'd0);
    wdata = wd[3];
    #1;
    chk("t1 wdata_ready[3]", 64'(wdata_ready), 64'd1);
    chk("t1 HWDATA[3]", 64'(HWDATA), 64'(wd[3]));
    step();
    chk("t1 done", 64'(done), 64'd1);
    chk("t1 cmd_ready after", 64'(cmd_ready), 64'd1);
    chk("t1 wdata_ready off", 64'(wdata_ready), 64'd0);
    step();
    chk("t1 done one cycle", 64'(done), 64'd0);

    // ---- WRAP8 read at 0x38
    issue("t2", 32'h38, 3'b100, 5'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("t2 HADDR[%0d]", i), 64'(HADDR), 64'(exp8[i]));
      chk($sformatf("t2 HTRANS[%0d]", i), 64'(HTRANS), (i == 0) ? 64'd2 : 64'd3);
      if (i > 0) HRDATA = 32'hD000_0000 + 32'(i - 1);
      if (i >= 2) begin
        chk($sformatf("t2 rdata_valid[%0d]", i - 2), 64'(rdata_valid), 64'd1);
        chk($sformatf("t2 rdata[%0d]", i - 2), 64'(rdata), 64'(32'hD000_0000 + 32'(i - 2)));
      end else begin
        chk($sformatf("t2 rdata_valid idle[%0d]", i), 64'(rdata_valid), 64'd0);
      end
    end
    step();
    chk("t2 last HTRANS", 64'(HTRANS), 64'd0);
    chk("t2 rdata_valid[6]", 64'(rdata_valid), 64'd1);
    chk("t2 rdata[6]", 64'(rdata), 64'h0000_0000_D000_0006);
    HRDATA = 32'hD000_0007;
    step();
    chk("t2 done", 64'(done), 64'd1);
    chk("t2 rdata_valid[7]", 64'(rdata_valid), 64'd1);
    chk("t2 rdata[7]", 64'(rdata), 64'h0000_0000_D000_0007);
    step();
    chk("t2 rdata_valid off", 64'(rdata_valid), 64'd0);

    // ---- INCR len 3, HREADY low 2 cycles on beat 2
    issue("t3", 32'h200, 3'b001, 5'd3, 1'b0);
    step();
    chk("t3 HADDR0", 64'(HADDR), 64'h200);
    chk("t3 HTRANS0", 64'(HTRANS), 64'd2);
    chk("t3 HBURST", 64'(HBURST), 64'd1);
    step();
    chk("t3 HADDR1", 64'(HADDR), 64'h204);
    chk("t3 HTRANS1", 64'(HTRANS), 64'd3);
    HREADY = 1'b0;
    HRDATA = 32'hA1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("t3 stall HADDR[%0d]", k), 64'(HADDR), 64'h204);
      chk($sformatf("t3 stall HTRANS[%0d]", k), 64'(HTRANS), 64'd3);
      chk($sformatf("t3 stall rdata_valid[%0d]", k), 64'(rdata_valid), 64'd0);
    end
    HREADY = 1'b1;
    step();
    chk("t3 HADDR2", 64'(HADDR), 64'h208);
    chk("t3 HTRANS2", 64'(HTRANS), 64'd3);
    chk("t3 HBUSREQ before last", 64'(HBUSREQ), 64'd1);
    chk("t3 rdata beat0", 64'(rdata), 64'hA1);
    HRDATA = 32'hA2;
    step();
    chk("t3 last HTRANS", 64'(HTRANS), 64'd0);
    chk("t3 HBUSREQ low", 64'(HBUSREQ), 64'd0);
    chk("t3 rdata beat1", 64'(rdata), 64'hA2);
    HRDATA = 32'hA3;
    step();
    chk("t3 done", 64'(done), 64'd1);
    chk("t3 rdata beat2", 64'(rdata), 64'hA3);
    step();

    // ---- INCR16 at 0x0, grant lost on beat 5 acceptance
    issue("t4", 32'h0, 3'b111, 5'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t4 HADDR[%0d]", i), 64'(HADDR), 64'(4 * i));
      chk($sformatf("t4 HTRANS[%0d]", i), 64'(HTRANS), (i == 0) ? 64'd2 : 64'd3);
      if (i == 0) chk("t4 HBURST", 64'(HBURST), 64'd7);
    end
    HGRANT = 1'b0;
    step();
    chk("t4 lost HTRANS", 64'(HTRANS), 64'd0);
    chk("t4 lost HBUSREQ", 64'(HBUSREQ), 64'd1);
    chk("t4 lost HADDR", 64'(HADDR), 64'h14);
    step();
    chk("t4 wait HTRANS", 64'(HTRANS), 64'd0);
    chk("t4 wait HBUSREQ", 64'(HBUSREQ), 64'd1);
    chk("t4 pending data done", 64'(rdata_valid), 64'd1);
    HGRANT = 1'b1;
    for (int j = 0; j < 11; j++) begin
      step();
      chk($sformatf("t4 re HADDR[%0d]", j), 64'(HADDR), 64'(32'h14 + 4 * j));
      chk($sformatf("t4 re HTRANS[%0d]", j), 64'(HTRANS), (j == 0) ? 64'd2 : 64'd3);
      if (j == 0) chk("t4 re HBURST", 64'(HBURST), 64'd1);
    end
    step();
    chk("t4 last HTRANS", 64'(HTRANS), 64'd0);
    chk("t4 last HBUSREQ", 64'(HBUSREQ), 64'd0);
    step();
    chk("t4 done", 64'(done), 64'd1);
    step();

    // ---- reset during beat 3 of INCR8 write
    issue("t5", 32'h300, 3'b101, 5'd0, 1'b1);
    step();
    step();
    step();
    chk("t5 beat3 HADDR", 64'(HADDR), 64'h308);
    HRESET = 1'b1;
    step();
    check_reset("t5");
    HRESET = 1'b0;
    step();
    chk("t5 no done", 64'(done), 64'd0);
    chk("t5 idle HTRANS", 64'(HTRANS), 64'd0);

    // ---- SINGLE (cmd_len ignored), then INCR with cmd_len=0
    issue("t6", 32'h400, 3'b000, 5'd7, 1'b1);
    step();
    chk("t6 HTRANS", 64'(HTRANS), 64'd2);
    chk("t6 HBURST", 64'(HBURST), 64'd0);
    chk("t6 HADDR", 64'(HADDR), 64'h400);
    step();
    chk("t6 single only", 64'(HTRANS), 64'd0);
    chk("t6 HBUSREQ low", 64'(HBUSREQ), 64'd0);
    wdata = 32'h5A5A_5A5A;
    #1;
    chk("t6 wdata_ready", 64'(wdata_ready), 64'd1);
    step();
    chk("t6 done", 64'(done), 64'd1);

    issue("t7", 32'h500, 3'b001, 5'd0, 1'b0);
    step();
    chk("t7 HTRANS", 64'(HTRANS), 64'd2);
    chk("t7 HBURST", 64'(HBURST), 64'd1);
    step();
    chk("t7 one beat", 64'(HTRANS), 64'd0);
    step();
    chk("t7 done", 64'(done), 64'd1);
    step();
    chk("t7 done one cycle", 64'(done), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
